// File: rtl/hwpe_ctrl_package.sv
// Shared types and defaults for the HWPE control microcode scheduler.
package hwpe_ctrl_package;

  localparam int unsigned UCODE_SCHED_NB_REG    = 4;
  localparam int unsigned UCODE_SCHED_REG_WIDTH = 32;
  localparam int unsigned UCODE_SCHED_MAX_STEPS = 64;

  // Scheduler job phases.
  typedef enum logic [2:0] {
    SCHED_IDLE   = 3'd0,
    SCHED_CLEAR  = 3'd1,
    SCHED_STEP   = 3'd2,
    SCHED_ISSUE  = 3'd3,
    SCHED_FINISH = 3'd4,
    SCHED_ERROR  = 3'd5
  } ucode_sched_state_e;

  // One offset set as produced by the microcode engine, at default sizing.
  typedef struct packed {
    logic [UCODE_SCHED_NB_REG-1:0][UCODE_SCHED_REG_WIDTH-1:0] offs;
    logic                                                     done_seen;
  } ucode_offs_set_t;

endpackage

// File: rtl/hwpe_ctrl_ucode_sched.sv
// Steps the microcode engine one op at a time, forwards each offset set to
// the streamers over a valid/ready handshake and guards each step with a
// watchdog on the number of enable cycles.
module hwpe_ctrl_ucode_sched
  import hwpe_ctrl_package::*;
#(
  parameter int unsigned NB_REG     = UCODE_SCHED_NB_REG,
  parameter int unsigned REG_WIDTH  = UCODE_SCHED_REG_WIDTH,
  parameter int unsigned ITER_WIDTH = 16,
  parameter int unsigned MAX_STEPS  = UCODE_SCHED_MAX_STEPS
) (
  input  logic                               clk_i,
  input  logic                               rst_i,
  input  logic                               clear_i,
  input  logic                               start_i,
  output logic                               ucode_enable_o,
  output logic                               ucode_clear_o,
  input  logic                               ucode_valid_i,
  input  logic                               ucode_done_i,
  input  logic [NB_REG-1:0][REG_WIDTH-1:0]   ucode_offs_i,
  output logic [NB_REG-1:0][REG_WIDTH-1:0]   offs_o,
  output logic                               offs_valid_o,
  input  logic                               offs_ready_i,
  output logic                               busy_o,
  output logic                               done_o,
  output logic                               error_o,
  output logic [ITER_WIDTH-1:0]              iter_o
);

  localparam int unsigned CNT_WIDTH = $clog2(MAX_STEPS + 1);

  ucode_sched_state_e   state_q, state_d;
  logic [CNT_WIDTH-1:0] step_cnt_q;
  logic                 done_seen_q;
  logic                 capture_c;
  logic                 handshake_c;

  // Next-state decode; enable is combinational so a sampled event never
  // costs an extra engine advance.
  always_comb begin
    state_d        = state_q;
    ucode_enable_o = 1'b0;
    capture_c      = 1'b0;
    handshake_c    = 1'b0;
    unique case (state_q)
      SCHED_IDLE: begin
        if (start_i) state_d = SCHED_CLEAR;
      end
      SCHED_CLEAR: begin
        state_d = SCHED_STEP;
      end
      SCHED_STEP: begin
        ucode_enable_o = ~ucode_valid_i & ~ucode_done_i;
        if (ucode_valid_i) begin
          capture_c = 1'b1;
          state_d   = SCHED_ISSUE;
        end else if (ucode_done_i) begin
          state_d = SCHED_FINISH;
        end else if (step_cnt_q == CNT_WIDTH'(MAX_STEPS - 1)) begin
          state_d = SCHED_ERROR;
        end
      end
      SCHED_ISSUE: begin
        if (offs_ready_i) begin
          handshake_c = 1'b1;
          state_d     = done_seen_q ? SCHED_FINISH : SCHED_STEP;
        end
      end
      SCHED_FINISH: begin
        state_d = SCHED_IDLE;
      end
      SCHED_ERROR: begin
        state_d = SCHED_ERROR;
      end
      default: begin
        state_d = SCHED_IDLE;
      end
    endcase
    if (clear_i) state_d = SCHED_IDLE;
  end

  // State register with status outputs registered from the next state.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q       <= SCHED_IDLE;
      ucode_clear_o <= 1'b0;
      offs_valid_o  <= 1'b0;
      busy_o        <= 1'b0;
      done_o        <= 1'b0;
      error_o       <= 1'b0;
    end else begin
      state_q       <= state_d;
      ucode_clear_o <= (state_d == SCHED_CLEAR);
      offs_valid_o  <= (state_d == SCHED_ISSUE);
      busy_o        <= (state_d inside {SCHED_CLEAR, SCHED_STEP, SCHED_ISSUE, SCHED_FINISH});
      done_o        <= (state_d == SCHED_FINISH);
      error_o       <= (state_d == SCHED_ERROR);
    end
  end

  // Offset capture, iteration count and per-step watchdog counter.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      offs_o      <= '0;
      done_seen_q <= 1'b0;
      iter_o      <= '0;
      step_cnt_q  <= '0;
    end else if (clear_i) begin
      offs_o      <= '0;
      done_seen_q <= 1'b0;
      iter_o      <= '0;
      step_cnt_q  <= '0;
    end else begin
      if (capture_c) begin
        offs_o      <= ucode_offs_i;
        done_seen_q <= ucode_done_i;
      end
      if (state_d == SCHED_CLEAR) begin
        iter_o      <= '0;
        done_seen_q <= 1'b0;
      end else if (handshake_c) begin
        iter_o <= iter_o + ITER_WIDTH'(1);
      end
      if (state_q != SCHED_STEP) begin
        step_cnt_q <= '0;
      end else if (ucode_enable_o) begin
        step_cnt_q <= step_cnt_q + CNT_WIDTH'(1);
      end
    end
  end

endmodule

// File: tb/tb_hwpe_ctrl_ucode_sched.sv
// Bench for the microcode scheduler: a small engine stand-in, a job-level
// reference model compared every cycle, and directed scenarios with literal
// expectations.
module tb_hwpe_ctrl_ucode_sched;
  import hwpe_ctrl_package::*;

  localparam int unsigned NB_REG    = 4;
  localparam int unsigned REG_WIDTH = 32;
  localparam int unsigned ITER_W    = 16;
  localparam int          MAX_ST    = 64;

  localparam int PH_IDLE = 0, PH_CLR = 1, PH_STEP = 2, PH_ISSUE = 3, PH_FIN = 4, PH_ERR = 5;

  logic clk_i = 1'b0;
  logic rst_i = 1'b0;
  logic clear_i = 1'b0;
  logic start_i = 1'b0;
  logic offs_ready_i = 1'b1;
  logic ucode_enable_o, ucode_clear_o, offs_valid_o, busy_o, done_o, error_o;
  logic ucode_valid_i, ucode_done_i;
  logic [NB_REG-1:0][REG_WIDTH-1:0] ucode_offs_i, offs_o;
  logic [ITER_W-1:0] iter_o;

  int n_checks = 0;
  int n_fail   = 0;
  logic cmp_en = 1'b0;

  hwpe_ctrl_ucode_sched #(
    .NB_REG(NB_REG), .REG_WIDTH(REG_WIDTH), .ITER_WIDTH(ITER_W), .MAX_STEPS(MAX_ST)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i), .clear_i(clear_i), .start_i(start_i),
    .ucode_enable_o(ucode_enable_o), .ucode_clear_o(ucode_clear_o),
    .ucode_valid_i(ucode_valid_i), .ucode_done_i(ucode_done_i),
    .ucode_offs_i(ucode_offs_i), .offs_o(offs_o),
    .offs_valid_o(offs_valid_o), .offs_ready_i(offs_ready_i),
    .busy_o(busy_o), .done_o(done_o), .error_o(error_o), .iter_o(iter_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0b expected %0b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chkv(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Engine stand-in: offsets ready after ops_per_iter enables, done after last set.
  int unsigned stub_ops = 1, stub_iters = 1;
  logic stub_respond = 1'b1, stub_together = 1'b0;
  int unsigned s_ops, s_it;

  function automatic logic [NB_REG-1:0][REG_WIDTH-1:0] mk_offs(input int unsigned it);
    ucode_offs_set_t s;
    s = '0;
    for (int r = 0; r < NB_REG; r++) s.offs[r] = 32'(32'h1000 * (r + 1) + it);
    return s.offs;
  endfunction

  always @(posedge clk_i or posedge rst_i) begin
    if (rst_i || ucode_clear_o) begin
      s_ops <= 0; s_it <= 0;
      ucode_valid_i <= 1'b0; ucode_done_i <= 1'b0; ucode_offs_i <= '0;
    end else begin
      ucode_valid_i <= 1'b0;
      if (ucode_enable_o && stub_respond) begin
        if (s_ops + 1 == stub_ops) begin
          s_ops <= 0;
          s_it <= s_it + 1;
          ucode_valid_i <= 1'b1;
          ucode_offs_i <= mk_offs(s_it);
          if (stub_together && s_it + 1 == stub_iters) ucode_done_i <= 1'b1;
        end else begin
          s_ops <= s_ops + 1;
        end
      end
      if (!stub_together && ucode_valid_i && s_it == stub_iters) ucode_done_i <= 1'b1;
    end
  end

  // Event counters observed at each active edge.
  int en_cnt = 0, hs_cnt = 0, done_cnt = 0, clr_cnt = 0;
  always @(posedge clk_i) begin
    if (ucode_enable_o) en_cnt++;
    if (offs_valid_o && offs_ready_i) hs_cnt++;
    if (done_o) done_cnt++;
    if (ucode_clear_o) clr_cnt++;
  end

  // Job-level reference model driven only by the scheduler's inputs.
  int m_ph = PH_IDLE;
  int m_cnt = 0;
  logic m_ds = 1'b0;
  logic [ITER_W-1:0] m_iter = '0;
  logic [NB_REG-1:0][REG_WIDTH-1:0] m_offs = '0;

  always @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      m_ph = PH_IDLE; m_iter = '0; m_offs = '0; m_ds = 1'b0; m_cnt = 0;
    end else if (clear_i) begin
      m_ph = PH_IDLE; m_iter = '0; m_offs = '0; m_ds = 1'b0;
    end else begin
      case (m_ph)
        PH_IDLE: if (start_i) begin m_ph = PH_CLR; m_iter = '0; end
        PH_CLR: begin m_ph = PH_STEP; m_cnt = 0; end
        PH_STEP: begin
          if (ucode_valid_i) begin
            m_offs = ucode_offs_i; m_ds = ucode_done_i; m_ph = PH_ISSUE;
          end else if (ucode_done_i) begin
            m_ph = PH_FIN;
          end else begin
            m_cnt++;
            if (m_cnt == MAX_ST) m_ph = PH_ERR;
          end
        end
        PH_ISSUE: if (offs_ready_i) begin
          m_iter = m_iter + 16'd1; m_ph = m_ds ? PH_FIN : PH_STEP; m_cnt = 0;
        end
        PH_FIN: m_ph = PH_IDLE;
        default: ;
      endcase
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk_i) begin
    if (cmp_en) begin
      chk1("cyc_enable", ucode_enable_o, (m_ph == PH_STEP) && !ucode_valid_i && !ucode_done_i);
      chk1("cyc_uclear", ucode_clear_o, m_ph == PH_CLR);
      chk1("cyc_valid", offs_valid_o, m_ph == PH_ISSUE);
      chk1("cyc_busy", busy_o, m_ph inside {PH_CLR, PH_STEP, PH_ISSUE, PH_FIN});
      chk1("cyc_done", done_o, m_ph == PH_FIN);
      chk1("cyc_error", error_o, m_ph == PH_ERR);
      chkv("cyc_iter", 128'(iter_o), 128'(m_iter));
      chkv("cyc_offs", 128'(offs_o), 128'(m_offs));
    end
  end

  function automatic logic cond(input int which);
    case (which)
      0: return offs_valid_o;
      1: return !busy_o;
      2: return error_o;
      default: return offs_valid_o && (iter_o == 16'd1);
    endcase
  endfunction

  task automatic wait_cond(input string name, input int which, input int budget);
    int n = 0;
    while (!cond(which) && n < budget) begin
      @(negedge clk_i);
      n++;
    end
    chk1(name, cond(which), 1'b1);
  endtask

  task automatic pulse_start();
    @(negedge clk_i) start_i = 1'b1;
    @(negedge clk_i) start_i = 1'b0;
  endtask

  task automatic chk_all_zero(input string name);
    chkv(name, {ucode_enable_o, ucode_clear_o, offs_valid_o, busy_o, done_o, error_o, iter_o}, '0);
    chkv(name, 128'(offs_o), '0);
  endtask

  int en0, hs0, dn0, cl0;

  initial begin
    #1 rst_i = 1'b1;
    #2 chk_all_zero("reset_outputs");
    repeat (2) @(negedge clk_i);
    rst_i = 1'b0;
    cmp_en = 1'b1;

    // Four sets after three enables each, then done.
    stub_ops = 3; stub_iters = 4; stub_respond = 1'b1; stub_together = 1'b0;
    en0 = en_cnt; hs0 = hs_cnt; dn0 = done_cnt;
    pulse_start();
    wait_cond("job4_end", 1, 200);
    chkv("job4_handshakes", 128'(hs_cnt - hs0), 128'(4));
    chkv("job4_enables", 128'(en_cnt - en0), 128'(12));
    chkv("job4_done_pulses", 128'(done_cnt - dn0), 128'(1));
    chkv("job4_iter", 128'(iter_o), 128'(4));
    chkv("job4_last_offs", 128'(offs_o), 128'h00004003_00003003_00002003_00001003);

    // Streamer back-pressure for ten cycles.
    stub_ops = 2; stub_iters = 1;
    offs_ready_i = 1'b0;
    pulse_start();
    wait_cond("stall_valid", 0, 50);
    for (int i = 0; i < 10; i++) begin
      chk1("stall_valid_held", offs_valid_o, 1'b1);
      chk1("stall_enable_low", ucode_enable_o, 1'b0);
      chkv("stall_iter", 128'(iter_o), 128'(0));
      chkv("stall_offs", 128'(offs_o), 128'h00004000_00003000_00002000_00001000);
      @(negedge clk_i);
    end
    offs_ready_i = 1'b1;
    wait_cond("stall_end", 1, 50);
    chkv("stall_iter_final", 128'(iter_o), 128'(1));

    // Valid and done together on the last set.
    stub_ops = 1; stub_iters = 2; stub_together = 1'b1;
    pulse_start();
    wait_cond("tog_last_issue", 3, 50);
    @(negedge clk_i);
    chk1("tog_done_after_hs", done_o, 1'b1);
    chkv("tog_iter", 128'(iter_o), 128'(2));
    @(negedge clk_i);
    chk1("tog_done_single", done_o, 1'b0);
    chk1("tog_idle", busy_o, 1'b0);

    // Unresponsive engine trips the watchdog.
    stub_together = 1'b0; stub_respond = 1'b0;
    en0 = en_cnt;
    pulse_start();
    wait_cond("wd_error", 2, 200);
    chkv("wd_enables", 128'(en_cnt - en0), 128'(MAX_ST));
    chk1("wd_busy", busy_o, 1'b0);
    repeat (3) @(negedge clk_i);
    chk1("wd_error_sticky", error_o, 1'b1);
    chk1("wd_enable_low", ucode_enable_o, 1'b0);
    clear_i = 1'b1;
    @(negedge clk_i) clear_i = 1'b0;
    chk1("wd_cleared", error_o, 1'b0);
    chk1("wd_cleared_busy", busy_o, 1'b0);

    // Start ignored while stepping.
    stub_respond = 1'b1; stub_ops = 4; stub_iters = 2;
    dn0 = done_cnt; cl0 = clr_cnt;
    pulse_start();
    @(negedge clk_i);
    @(negedge clk_i) start_i = 1'b1;
    @(negedge clk_i) start_i = 1'b0;
    wait_cond("ign_end", 1, 100);
    chkv("ign_iter", 128'(iter_o), 128'(2));
    chkv("ign_done_pulses", 128'(done_cnt - dn0), 128'(1));
    chkv("ign_engine_clears", 128'(clr_cnt - cl0), 128'(1));

    // Soft clear while issuing withdraws valid next cycle.
    offs_ready_i = 1'b0;
    pulse_start();
    wait_cond("clr_issue", 0, 50);
    clear_i = 1'b1;
    @(negedge clk_i) clear_i = 1'b0;
    chk1("clr_valid_drop", offs_valid_o, 1'b0);
    chk1("clr_busy", busy_o, 1'b0);
    chkv("clr_offs", 128'(offs_o), '0);
    chkv("clr_iter", 128'(iter_o), 128'(0));
    offs_ready_i = 1'b1;

    // Asynchronous reset mid-step, then a fresh job.
    stub_respond = 1'b0;
    pulse_start();
    repeat (5) @(negedge clk_i);
    chk1("rst_pre_busy", busy_o, 1'b1);
    #2 rst_i = 1'b1;
    #1 chk_all_zero("rst_async");
    stub_respond = 1'b1; stub_ops = 2; stub_iters = 2;
    @(negedge clk_i) rst_i = 1'b0;
    dn0 = done_cnt; cl0 = clr_cnt;
    pulse_start();
    wait_cond("rst_job_end", 1, 100);
    chkv("rst_engine_clears", 128'(clr_cnt - cl0), 128'(1));
    chkv("rst_iter", 128'(iter_o), 128'(2));
    chkv("rst_done_pulses", 128'(done_cnt - dn0), 128'(1));

    repeat (2) @(negedge clk_i);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/hwpe_ctrl_ucode_sched.md
HWPE_CTRL_UCODE_SCHED -- requirements
Module: hwpe_ctrl_ucode_sched

Interface
REQ-001 SHALL have parameter NB_REG, default 4: number of offset registers forwarded from the microcode engine.
REQ-002 SHALL have parameter REG_WIDTH, default 32: offset register width.
REQ-003 SHALL have parameter ITER_WIDTH, default 16: width of the iteration counter.
REQ-004 SHALL have parameter MAX_STEPS, default 64: watchdog limit on enable cycles per step.
REQ-005 SHALL use one clock and an asynchronous, active-high reset.
REQ-006 SHALL have port clk_i, input, 1: clock.
REQ-007 SHALL have port rst_i, input, 1: asynchronous active-high reset.
REQ-008 SHALL have port clear_i, input, 1: synchronous soft clear.
REQ-009 SHALL have port start_i, input, 1: job start pulse.
REQ-010 SHALL have port ucode_enable_o, output, 1: advance the microcode engine by one op.
REQ-011 SHALL have port ucode_clear_o, output, 1: clear the microcode engine.
REQ-012 SHALL have port ucode_valid_i, input, 1: engine offsets updated.
REQ-013 SHALL have port ucode_done_i, input, 1: engine loop nest finished.
REQ-014 SHALL have port ucode_offs_i, input, NB_REG x REG_WIDTH: engine offsets.
REQ-015 SHALL have port offs_o, output, NB_REG x REG_WIDTH: registered offsets sent to the streamers.
REQ-016 SHALL have port offs_valid_o, input/ready pair, 1 each: offs_valid_o output and offs_ready_i input, forming the streamer handshake.
REQ-017 SHALL have port busy_o, output, 1: job in progress.
REQ-018 SHALL have port done_o, output, 1: one-cycle end-of-job pulse.
REQ-019 SHALL have port error_o, output, 1: sticky watchdog error.
REQ-020 SHALL have port iter_o, output, ITER_WIDTH: number of offset sets accepted in the current job.

Function
REQ-021 SHALL implement the FSM states IDLE, CLEAR, STEP, ISSUE, FINISH and ERROR.
REQ-022 IDLE: start_i -> CLEAR; start_i SHALL be ignored in every other state.
REQ-023 CLEAR: ucode_clear_o=1 for exactly one cycle, iter_o reset to 0, then -> STEP.
REQ-024 STEP: ucode_enable_o = ~ucode_valid_i & ~ucode_done_i, combinational, so no extra advance occurs in the cycle the event is sampled.
REQ-025 STEP on ucode_valid_i=1 SHALL capture ucode_offs_i into offs_o, record done_seen=ucode_done_i, and go -> ISSUE.
REQ-026 STEP on ucode_done_i=1 with ucode_valid_i=0 SHALL go -> FINISH without issuing.
REQ-027 STEP SHALL count the cycles in which enable is asserted, restart the count on STEP entry, and go -> ERROR when the count reaches MAX_STEPS.
REQ-028 ISSUE: offs_valid_o=1, and offs_o SHALL be held stable until offs_ready_i.
REQ-029 On the ISSUE handshake, iter_o SHALL increment (wrap at 2^ITER_WIDTH), then go -> FINISH if done_seen, else -> STEP.
REQ-030 FINISH: done_o=1 for one cycle, then -> IDLE.
REQ-031 ERROR: error_o=1 and ucode_enable_o=0; remain in ERROR until clear_i or reset.
REQ-032 busy_o=1 in every state except IDLE and ERROR.
REQ-033 clear_i SHALL have priority over all transitions and SHALL force IDLE, error_o=0, iter_o=0 and offs_o=0.
REQ-034 clear_i during ISSUE SHALL drop offs_valid_o the next cycle; this is the only permitted valid withdrawal.

Reset
REQ-035 Reset SHALL set state=IDLE and drive all outputs to 0, including offs_o, iter_o, error_o and done_seen.
REQ-036 Reset mid-job SHALL abort immediately; the engine is re-cleared on the next start.

Structure
REQ-037 The state enum and the offset-set struct SHALL live in hwpe_ctrl_package; MAX_STEPS defaults there as UCODE_SCHED_MAX_STEPS.
REQ-038 The block SHALL be a single module with no sub-modules; the engine is instantiated beside it by the parent.

Verification
REQ-039 start; engine gives valid after 3 enables x 4 iterations, then done -> 4 handshakes, iter_o=4, single done_o, 12 enable cycles.
REQ-040 offs_ready_i held low 10 cycles in ISSUE -> offs_o stable, ucode_enable_o=0 throughout, iter_o unchanged.
REQ-041 ucode_valid_i and ucode_done_i together -> one final issue, then done_o the cycle after the handshake.
REQ-042 engine never responds, MAX_STEPS=64 -> error_o=1 after 64 enable cycles, busy_o=0; clear_i -> IDLE, error_o=0.
REQ-043 start_i pulsed during STEP -> ignored, job count unaffected; clear_i during ISSUE -> offs_valid_o=0 next cycle.
REQ-044 rst_i asserted mid-STEP -> all outputs 0 asynchronously; a new start restarts with ucode_clear_o pulse.
